// File: rtl/urna_pkg.sv
// rtl/urna_pkg.sv - shared types and constants for the vote tally block
// Contents: FSM state enum, readout select encodings, vote-kind constants,
//           and the vote classification helper.
package urna_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REGISTER = 2'd1,
        ST_ACK      = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    // Readout selects double as counter indices.
    localparam logic [2:0] SEL_C0    = 3'd0;
    localparam logic [2:0] SEL_C1    = 3'd1;
    localparam logic [2:0] SEL_C2    = 3'd2;
    localparam logic [2:0] SEL_BLANK = 3'd3;
    localparam logic [2:0] SEL_NULL  = 3'd4;
    localparam logic [2:0] SEL_TOTAL = 3'd5;
    localparam int         NUM_CNT   = 6;

    localparam logic KIND_CONFIRM = 1'b0;
    localparam logic KIND_BLANK   = 1'b1;

    // Returns the counter index a registered vote lands in. Candidates are
    // tested in order so equal candidate numbers resolve to the lowest index.
    function automatic logic [2:0] classify(
        input logic       kind,
        input logic [3:0] tens,
        input logic [3:0] units,
        input int         c0,
        input int         c1,
        input int         c2
    );
        int         value;
        logic [2:0] sel;
        sel   = SEL_NULL;
        value = 10 * int'(tens) + int'(units);
        if (kind == KIND_BLANK) begin
            sel = SEL_BLANK;
        end else if (tens <= 4'd9 && units <= 4'd9) begin
            if (value == c0) begin
                sel = SEL_C0;
            end else if (value == c1) begin
                sel = SEL_C1;
            end else if (value == c2) begin
                sel = SEL_C2;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - pushbutton synchroniser with falling-edge press pulse
// Ports: clk, rst (sync, active-high); key_n async active-low pin;
//        pulse one-cycle press strobe; level synchronised pin value.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse,
    output logic level
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    // The press strobe is registered, so a pin first sampled low at edge k
    // shows up as a pulse in the cycle after edge k+2.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = ~sync2_q & prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign level = sync2_q;

endmodule

// File: rtl/vote_tally.sv
// rtl/vote_tally.sv - classifies and counts votes from the candidate entry stage
// Ports: clk, rst (sync, active-high); bcd_tens/bcd_units current selection;
//        key_confirma/key_branco active-low async keys; voting_en gate;
//        res_sel/res_count counter readout; vote_ok acknowledgement; busy.
module vote_tally
    import urna_pkg::*;
#(
    parameter int CAND0      = 13,
    parameter int CAND1      = 45,
    parameter int CAND2      = 22,
    parameter int COUNT_W    = 8,
    parameter int ACK_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         bcd_tens,
    input  logic [3:0]         bcd_units,
    input  logic               key_confirma,
    input  logic               key_branco,
    input  logic               voting_en,
    input  logic [2:0]         res_sel,
    output logic [COUNT_W-1:0] res_count,
    output logic               vote_ok,
    output logic               busy
);

    localparam int              ACK_W    = $clog2(ACK_CYCLES + 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);

    logic conf_pulse, conf_level;
    logic bran_pulse, bran_level;

    state_e             state_q, state_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         units_q, units_d;
    logic               kind_q, kind_d;
    logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [COUNT_W-1:0] cnt_q [NUM_CNT];
    logic [COUNT_W-1:0] cnt_d [NUM_CNT];
    logic [2:0]         hit;

    key_edge u_key_confirma (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_confirma),
        .pulse (conf_pulse),
        .level (conf_level)
    );

    key_edge u_key_branco (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_branco),
        .pulse (bran_pulse),
        .level (bran_level)
    );

    always_comb begin
        hit = classify(kind_q, tens_q, units_q, CAND0, CAND1, CAND2);
    end

    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        units_d   = units_q;
        kind_d    = kind_q;
        ack_cnt_d = ack_cnt_q;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (voting_en && (conf_pulse || bran_pulse)) begin
                    tens_d  = bcd_tens;
                    units_d = bcd_units;
                    // Simultaneous presses count once, as a blank vote.
                    kind_d  = bran_pulse ? KIND_BLANK : KIND_CONFIRM;
                    state_d = ST_REGISTER;
                end
            end
            ST_REGISTER: begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if ((i == int'(hit) || i == int'(SEL_TOTAL)) &&
                        cnt_q[i] != {COUNT_W{1'b1}}) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                ack_cnt_d = '0;
                state_d   = ST_ACK;
            end
            ST_ACK: begin
                if (ack_cnt_q == ACK_LAST) begin
                    state_d = ST_RELEASE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // Keys still held from the last vote must come up first.
                if (conf_level && bran_level) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tens_q    <= '0;
            units_q   <= '0;
            kind_q    <= KIND_CONFIRM;
            ack_cnt_q <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            kind_q    <= kind_d;
            ack_cnt_q <= ack_cnt_d;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        res_count = '0;
        case (res_sel)
            SEL_C0:    res_count = cnt_q[0];
            SEL_C1:    res_count = cnt_q[1];
            SEL_C2:    res_count = cnt_q[2];
            SEL_BLANK: res_count = cnt_q[3];
            SEL_NULL:  res_count = cnt_q[4];
            SEL_TOTAL: res_count = cnt_q[5];
            default:   res_count = '0;
        endcase
    end

    assign vote_ok = (state_q == ST_ACK);
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vote_tally.sv
// tb/tb_vote_tally.sv - self-checking bench for vote_tally
module tb_vote_tally;

    localparam int ACK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd_tens = '0;
    logic [3:0] bcd_units = '0;
    logic       key_confirma = 1'b1;
    logic       key_branco = 1'b1;
    logic       voting_en = 1'b1;
    logic [2:0] res_sel = '0;
    logic [7:0] res_a;
    logic [1:0] res_b;
    logic       ok_a, ok_b, busy_a, busy_b;

    int checks = 0;
    int failures = 0;
    int model_cnt [6];

    always #10 clk = ~clk;

    vote_tally #(.COUNT_W(8), .ACK_CYCLES(ACK)) dut_a (
        .clk(clk), .rst(rst), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
        .key_confirma(key_confirma), .key_branco(key_branco),
        .voting_en(voting_en), .res_sel(res_sel), .res_count(res_a),
        .vote_ok(ok_a), .busy(busy_a)
    );

    vote_tally #(.COUNT_W(2), .ACK_CYCLES(ACK)) dut_b (
        .clk(clk), .rst(rst), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
        .key_confirma(key_confirma), .key_branco(key_branco),
        .voting_en(voting_en), .res_sel(res_sel), .res_count(res_b),
        .vote_ok(ok_b), .busy(busy_b)
    );

    // Reference rules: 0..2 candidates, 3 blank, 4 null.
    function automatic int ref_class(bit blank, int t, int u);
        int v;
        if (blank) return 3;
        if (t < 10 && u < 10) begin
            v = t * 10 + u;
            if (v == 13) return 0;
            if (v == 45) return 1;
            if (v == 22) return 2;
        end
        return 4;
    endfunction

    function automatic int exp_w(int idx, int maxv);
        if (idx > 5) return 0;
        return (model_cnt[idx] > maxv) ? maxv : model_cnt[idx];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            res_sel = 3'(i);
            #1;
            check($sformatf("%s_a%0d", tag, i), {24'd0, res_a}, exp_w(i, 255));
            check($sformatf("%s_b%0d", tag, i), {30'd0, res_b}, exp_w(i, 3));
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (busy_a === 1'b0) break;
            tick;
        end
        check({tag, "_idle"}, {31'd0, busy_a}, 0);
    endtask

    // mode 0: release after ACK; 1: release mid-ACK and re-press confirma;
    // 2: hold both keys through ACK and into RELEASE.
    task automatic cast(input int t, input int u, input bit c, input bit b,
                        input int mode, input string tag);
        int idx;
        int n;
        idx = ref_class(b, t, u);
        bcd_tens = 4'(t);
        bcd_units = 4'(u);
        res_sel = 3'(idx);
        key_confirma = c ? 1'b0 : 1'b1;
        key_branco = b ? 1'b0 : 1'b1;
        tick;
        tick;
        tick;
        tick;
        check({tag, "_old"}, {24'd0, res_a}, exp_w(idx, 255));
        check({tag, "_busy"}, {31'd0, busy_a}, 1);
        model_cnt[idx]++;
        model_cnt[5]++;
        tick;
        check({tag, "_new_a"}, {24'd0, res_a}, exp_w(idx, 255));
        check({tag, "_new_b"}, {30'd0, res_b}, exp_w(idx, 3));
        check({tag, "_ok"}, {31'd0, ok_a}, 1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (mode == 1 && n == 1) begin
                key_confirma = 1'b1;
                key_branco = 1'b1;
            end
            if (mode == 1 && n == 2) key_confirma = 1'b0;
            tick;
            if (ok_a !== 1'b1) break;
            n++;
        end
        check({tag, "_acklen"}, n, ACK);
        if (mode != 0) begin
            for (int i = 0; i < 6; i++) tick;
            check({tag, "_held"}, {31'd0, busy_a}, 1);
        end
        key_confirma = 1'b1;
        key_branco = 1'b1;
        wait_idle(tag);
        tick;
        tick;
        check_all(tag);
    endtask

    initial begin
        bit seen;
        int r, t, u, k;
        for (int i = 0; i < 6; i++) model_cnt[i] = 0;

        rst = 1'b1;
        tick;
        tick;
        tick;
        rst = 1'b0;
        tick;
        check("rst_ok", {31'd0, ok_a}, 0);
        check("rst_busy", {31'd0, busy_a}, 0);
        check_all("rst");

        cast(1, 3, 1, 0, 0, "cand0");
        cast(9, 9, 1, 0, 0, "null99");
        cast(9, 9, 0, 1, 0, "blank");
        cast(0, 0, 1, 0, 0, "null00");
        cast(13, 4, 1, 0, 0, "nullhex");
        cast(4, 5, 1, 1, 2, "both_hold");
        cast(2, 2, 1, 1, 1, "both_repress");
        for (int i = 0; i < 4; i++) cast(4, 5, 1, 0, 0, $sformatf("c1_%0d", i));

        voting_en = 1'b0;
        bcd_tens = 4'd4;
        bcd_units = 4'd5;
        key_confirma = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            seen |= busy_a;
        end
        check("disabled_busy", {31'd0, seen}, 0);
        key_confirma = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        voting_en = 1'b1;
        tick;
        check_all("disabled");

        for (int v = 0; v < 12; v++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: begin t = 1; u = 3; end
                1: begin t = 4; u = 5; end
                2: begin t = 2; u = 2; end
                default: begin t = $urandom_range(0, 15); u = $urandom_range(0, 15); end
            endcase
            k = $urandom_range(0, 2);
            cast(t, u, k != 1, k != 0, 0, $sformatf("rnd%0d", v));
        end

        bcd_tens = 4'd1;
        bcd_units = 4'd3;
        key_confirma = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        check("mid_ack_ok", {31'd0, ok_a}, 1);
        rst = 1'b1;
        key_confirma = 1'b1;
        tick;
        for (int i = 0; i < 6; i++) model_cnt[i] = 0;
        check("rst_ack_ok", {31'd0, ok_a}, 0);
        check("rst_ack_busy", {31'd0, busy_a}, 0);
        check_all("rst_ack");
        rst = 1'b0;
        tick;
        tick;
        cast(2, 2, 1, 0, 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
